// File: rtl/serial_add_ctrl_if.sv
// Bundle of the request/response handshake and the full-adder cell link for
// serial_add_ctrl. The controller uses the slave view. The master view belongs
// to the environment: the requester plus the external 1-bit full adder.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    // Requester -> controller
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;

    // Controller -> requester
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    // Controller <-> shared full-adder cell
    logic             fa_x;
    logic             fa_y;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;

    modport master (
        output start, a, b, c_in, fa_s, fa_cout,
        input  ready, busy, done, sum, c_out, fa_x, fa_y, fa_cin
    );

    modport slave (
        input  start, a, b, c_in, fa_s, fa_cout,
        output ready, busy, done, sum, c_out, fa_x, fa_y, fa_cin
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. It feeds one external 1-bit full adder one bit
// position per cycle, LSB first, for WIDTH cycles. It collects the sum bits
// into an accumulator and chains the carry through a register. The result is
// {c_out, sum} = a + b + c_in. Handshake: ready in IDLE, busy in RUN/DONE, and
// a one-cycle done pulse when the result registers are updated.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);

    // Bit counter needs clog2(WIDTH) bits, but never fewer than one.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             c_out_q,  c_out_d;

    // Accumulator after absorbing this cycle's sum bit at the MSB. Writing it
    // as a shift of {fa_s, acc} keeps it valid for WIDTH=1, where an
    // acc[WIDTH-1:1] slice would not exist.
    logic [WIDTH-1:0] acc_shift;
    logic             in_run;

    assign acc_shift = WIDTH'({bus.fa_s, acc_q} >> 1);
    assign in_run    = (state_q == S_RUN);

    // Moore outputs decoded from the state register. The adder inputs are
    // forced to 0 outside RUN, so the shared cell sees no activity.
    assign bus.ready  = (state_q == S_IDLE);
    assign bus.busy   = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.sum    = sum_q;
    assign bus.c_out  = c_out_q;
    assign bus.fa_x   = in_run & a_sh_q[0];
    assign bus.fa_y   = in_run & b_sh_q[0];
    assign bus.fa_cin = in_run & carry_q;

    // Next-state logic: load operands on accept, step one bit per RUN cycle,
    // and capture the result on the last bit.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;

        case (state_q)
            S_IDLE: begin
                // Operands are captured here only. Later changes on a/b/c_in
                // cannot affect an operation in flight.
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.c_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                acc_d   = acc_shift;
                carry_d = bus.fa_cout;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = acc_shift;
                    c_out_d = bus.fa_cout;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // start is ignored here. The requester must present it again
                // (or keep holding it) once ready returns.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything, including a
    // result from an earlier operation, and drops any operation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl. A WIDTH=8 instance gets directed
// and random additions, a start held through an operation, and a reset in the
// middle of RUN. A WIDTH=1 instance is swept through the full-adder truth
// table. Expected results come from plain integer addition.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    // External full-adder cells
    assign bus8.fa_s    = bus8.fa_x ^ bus8.fa_y ^ bus8.fa_cin;
    assign bus8.fa_cout = (bus8.fa_x & bus8.fa_y) | (bus8.fa_x & bus8.fa_cin) | (bus8.fa_y & bus8.fa_cin);
    assign bus1.fa_s    = bus1.fa_x ^ bus1.fa_y ^ bus1.fa_cin;
    assign bus1.fa_cout = (bus1.fa_x & bus1.fa_y) | (bus1.fa_x & bus1.fa_cin) | (bus1.fa_y & bus1.fa_cin);

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the full-width sum of the operands.
    function automatic logic [8:0] ref_add8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        return {1'b0, av} + {1'b0, bv} + {8'b0, cv};
    endfunction

    // Present an operation to the WIDTH=8 unit; it is accepted on the next edge.
    task automatic start_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input string tag);
        @(negedge clk);
        check({tag, " ready before start"}, bus8.ready, 1'b1);
        bus8.start = 1'b1;
        bus8.a     = av;
        bus8.b     = bv;
        bus8.c_in  = cv;
    endtask

    // Follow an accepted operation up to its done pulse. Operands are scrambled
    // every cycle. The number of busy cycles before done and the result are checked.
    task automatic wait_result8(input logic [8:0] exp, input bit drop_start, input string tag);
        int busy_cycles = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (drop_start) bus8.start = 1'b0;
            if (bus8.done) begin
                seen = 1'b1;
            end else begin
                if (bus8.busy && !bus8.ready) busy_cycles++;
                bus8.a    = 8'($urandom);
                bus8.b    = 8'($urandom);
                bus8.c_in = 1'($urandom);
            end
        end
        if (!seen) begin
            check({tag, " done timeout"}, 32'd0, 32'd1);
        end else begin
            $display("op %s: sum=0x%02h c_out=%0b expect {c_out,sum}=0x%03h after %0d run cycles",
                     tag, bus8.sum, bus8.c_out, exp, busy_cycles);
            check({tag, " run cycles"}, busy_cycles, 32'd8);
            check({tag, " sum"}, bus8.sum, {24'd0, exp[7:0]});
            check({tag, " c_out"}, bus8.c_out, {31'd0, exp[8]});
            check({tag, " busy in done"}, {bus8.busy, bus8.ready}, 2'b10);
            check({tag, " fa idle in done"}, {bus8.fa_x, bus8.fa_y, bus8.fa_cin}, 3'b000);
        end
    endtask

    // The cycle after done: the pulse has ended, the unit is idle, and the result is held.
    task automatic after_done8(input logic [7:0] exp_sum, input string tag);
        @(negedge clk);
        check({tag, " done one cycle"}, bus8.done, 1'b0);
        check({tag, " idle after done"}, {bus8.ready, bus8.busy}, 2'b10);
        check({tag, " sum held"}, bus8.sum, {24'd0, exp_sum});
    endtask

    initial begin
        logic [7:0] av, bv;
        logic       cv;
        logic [8:0] e;
        bit         saw_done;

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;

        // Reset state
        #1;
        check("reset ready/busy/done", {bus8.ready, bus8.busy, bus8.done}, 3'b100);
        check("reset sum", bus8.sum, 32'd0);
        check("reset c_out", bus8.c_out, 32'd0);
        check("reset fa inputs", {bus8.fa_x, bus8.fa_y, bus8.fa_cin}, 3'b000);
        check("reset w1 ready/busy/done", {bus1.ready, bus1.busy, bus1.done}, 3'b100);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed operations
        start_op8(8'h5A, 8'h33, 1'b0, "5A+33");
        wait_result8(9'h08D, 1'b1, "5A+33");
        after_done8(8'h8D, "5A+33");

        start_op8(8'hFF, 8'h01, 1'b0, "FF+01");
        wait_result8(9'h100, 1'b1, "FF+01");
        after_done8(8'h00, "FF+01");

        start_op8(8'hFF, 8'hFF, 1'b1, "FF+FF+1");
        wait_result8(9'h1FF, 1'b1, "FF+FF+1");
        after_done8(8'hFF, "FF+FF+1");

        // Reset in RUN cycle 4: everything returns to reset values and no done appears
        start_op8(8'hC3, 8'h5A, 1'b1, "rst mid-run");
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst mid-run ready/busy/done", {bus8.ready, bus8.busy, bus8.done}, 3'b100);
        check("rst mid-run sum cleared", bus8.sum, 32'd0);
        check("rst mid-run c_out cleared", bus8.c_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) saw_done = 1'b1;
        end
        check("rst mid-run no done", saw_done, 1'b0);
        $display("op rst mid-run: unit idle after reset, sum=0x%02h", bus8.sum);

        start_op8(8'h01, 8'h01, 1'b0, "01+01");
        wait_result8(9'h002, 1'b1, "01+01");
        after_done8(8'h02, "01+01");

        // start held through a whole op while operands change. The second op
        // starts only from IDLE and uses the operands present at that point.
        start_op8(8'h12, 8'h34, 1'b1, "hold first");
        wait_result8(ref_add8(8'h12, 8'h34, 1'b1), 1'b0, "hold first");
        bus8.a    = 8'h80;
        bus8.b    = 8'h7F;
        bus8.c_in = 1'b1;
        after_done8(8'h47, "hold first");
        wait_result8(ref_add8(8'h80, 8'h7F, 1'b1), 1'b1, "hold second");
        after_done8(8'h00, "hold second");

        // Random operations
        for (int n = 0; n < 20; n++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            cv = 1'($urandom);
            e  = ref_add8(av, bv, cv);
            start_op8(av, bv, cv, "random");
            wait_result8(e, 1'b1, "random");
            after_done8(e[7:0], "random");
        end

        // WIDTH=1: one RUN cycle per op; {c_out,sum} follows the full-adder truth table
        for (int k = 0; k < 8; k++) begin
            logic [1:0] e1;
            e1 = 2'(k[2]) + 2'(k[1]) + 2'(k[0]);
            @(negedge clk);
            check("w1 ready before start", bus1.ready, 1'b1);
            bus1.start = 1'b1;
            bus1.a     = k[2];
            bus1.b     = k[1];
            bus1.c_in  = k[0];
            @(negedge clk);
            bus1.start = 1'b0;
            check("w1 run", {bus1.busy, bus1.done}, 2'b10);
            @(negedge clk);
            $display("op w1 %0b+%0b+%0b: c_out=%0b sum=%0b done=%0b expect %02b",
                     k[2], k[1], k[0], bus1.c_out, bus1.sum, bus1.done, e1);
            check("w1 done", bus1.done, 1'b1);
            check("w1 result", {bus1.c_out, bus1.sum}, e1);
            @(negedge clk);
            check("w1 idle after done", {bus1.ready, bus1.done}, 2'b10);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
